matscale_seq: RTL

- Time-multiplexed scalar-times-matrix engine: f = a * b, element by element, in the fixed-point format of the fixedp bundle.
- Instead of ROWS*COLS parallel multipliers, it sequences LANES multipliers over the matrix, trading latency for area.
- Sits where large matrices would make a fully parallel scaler too costly, e.g. a Kalman gain or covariance update.
- Valid/ready handshake on input and output.

---
 rtl/matscale_seq_pkg.sv | 21 ++
 rtl/matscale_seq_if.sv | 13 +
 rtl/matscale_seq_fixmul_lane.sv | 31 +++
 rtl/matscale_seq.sv | 134 +++++++++++++
 4 files changed

// File: rtl/matscale_seq_pkg.sv
// Shared types and sizing helpers for the time-multiplexed matrix scaler.
package matscale_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } seq_state_t;

    // Number of issue beats needed to cover n elements with the given lane count.
    function automatic int beats(input int n, input int lanes);
        return (lanes < 1) ? 0 : (n + lanes - 1) / lanes;
    endfunction

    // Counter width able to hold every value 0..n.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/matscale_seq_if.sv
// fixedp bundle: clock, synchronous active-low reset and the fixed-point format.
interface fixedp #(
    parameter int WIDTH    = 16,
    parameter int FRACBITS = 8
) (
    input logic clk,
    input logic reset_l
);

    modport master (input clk, input reset_l);
    modport slave  (input clk, input reset_l);

endinterface

// File: rtl/matscale_seq_fixmul_lane.sv
// One registered fixed-point multiplier lane: p <= low WIDTH bits of (a*b) >>> FRACBITS.
module fixmul_lane
    import matscale_seq_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int FRACBITS = 8
) (
    fixedp.slave                    g,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    en,
    output logic signed [WIDTH-1:0] p
);

    // Floor-rounding shift, then wrap to WIDTH bits.
    function automatic logic signed [WIDTH-1:0] scale_trunc(input logic signed [2*WIDTH-1:0] x);
        logic signed [2*WIDTH-1:0] s;
        s = x >>> FRACBITS;
        return s[WIDTH-1:0];
    endfunction

    logic signed [2*WIDTH-1:0] prod_p0;

    assign prod_p0 = (2*WIDTH)'(a) * (2*WIDTH)'(b);

    // p0 -> p1: product register
    always_ff @(posedge g.clk) begin
        if (en) p <= scale_trunc(prod_p0);
    end

endmodule

// File: rtl/matscale_seq.sv
// Scalar-times-matrix engine sequencing LANES multipliers over a row-major ROWSxCOLS operand.
module matscale_seq
    import matscale_seq_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int FRACBITS = 8,
    parameter int ROWS     = 1,
    parameter int COLS     = 1,
    parameter int LANES    = 1
) (
    fixedp.slave                             g,
    input  logic signed [WIDTH-1:0]          a,
    input  logic [ROWS:1][COLS:1][WIDTH-1:0] b,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [ROWS:1][COLS:1][WIDTH-1:0] f,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy
);

    localparam int N     = ROWS * COLS;
    localparam int BEATS = beats(N, LANES);
    localparam int IW    = idx_width(N);
    localparam int DEPTH = 2 ** IW;

    if (BEATS < 1 || LANES > N) begin : g_bad_lanes
        $error("matscale_seq: LANES must lie in 1..ROWS*COLS");
    end
    if (g.WIDTH != WIDTH || g.FRACBITS != FRACBITS) begin : g_bad_format
        $error("matscale_seq: WIDTH/FRACBITS disagree with the fixedp bundle");
    end

    seq_state_t              state;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           idx_p1;
    logic                    vld_p1;
    logic signed [WIDTH-1:0] a_op;
    logic signed [WIDTH-1:0] b_op    [DEPTH];
    logic signed [WIDTH-1:0] f_r     [DEPTH];
    logic signed [WIDTH-1:0] lane_p1 [LANES];
    logic [N*WIDTH-1:0]      b_flat;
    logic [N*WIDTH-1:0]      f_flat;

    assign b_flat   = b;
    assign f        = f_flat;
    assign in_ready = g.reset_l && (state == IDLE);
    assign busy     = g.reset_l && (state != IDLE);

    for (genvar k = 0; k < N; k++) begin : g_fout
        assign f_flat[k*WIDTH +: WIDTH] = f_r[k];
    end

    // p0: lane j picks element idx+j; lanes past the end of a partial beat stay idle
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        int            kk;
        logic          en;
        logic [IW-1:0] ksel;

        always_comb begin
            kk   = int'(idx) + j;
            en   = (state == RUN) && (kk < N);
            ksel = en ? IW'(kk) : '0;
        end

        fixmul_lane #(
            .WIDTH   (WIDTH),
            .FRACBITS(FRACBITS)
        ) u_lane (
            .g (g),
            .a (a_op),
            .b (b_op[ksel]),
            .en(en),
            .p (lane_p1[j])
        );
    end

    always_ff @(posedge g.clk) begin
        if (!g.reset_l) begin
            state     <= IDLE;
            idx       <= '0;
            idx_p1    <= '0;
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
            a_op      <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                b_op[k] <= '0;
                f_r[k]  <= '0;
            end
        end else begin
            vld_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_op <= a;
                        for (int k = 0; k < N; k++) b_op[k] <= b_flat[k*WIDTH +: WIDTH];
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    vld_p1 <= 1'b1;
                    idx_p1 <= idx;
                    // Wrap idx to 0 on the final beat so it never passes N.
                    if (int'(idx) + LANES >= N) begin
                        idx   <= '0;
                        state <= DRAIN;
                    end else begin
                        idx <= idx + IW'(LANES);
                    end
                end
                DRAIN: begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // p1 -> f: write-back demux of the beat issued last cycle
            for (int j = 0; j < LANES; j++) begin
                if (vld_p1 && (int'(idx_p1) + j < N)) f_r[IW'(int'(idx_p1) + j)] <= lane_p1[j];
            end
        end
    end

    a_idx_range: assert property (@(posedge g.clk) disable iff (!g.reset_l) int'(idx) <= N);

endmodule
